// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one partial product per clock, exact 2*WIDTH-bit product,
// per-transaction signed/unsigned mode, valid/ready handshake on operand and result sides.
module seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [2*WIDTH-1:0]   p_step;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     mag_a_in, mag_b_in, addend;
  logic [WIDTH:0]       sum;
  logic                 last;

  // Work on magnitudes; the most-negative value still fits as an unsigned magnitude.
  assign mag_a_in = (signed_mode && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
  assign mag_b_in = (signed_mode && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;

  // Add into the upper half with a carry bit, then shift the whole thing right by one.
  assign addend = p_q[0] ? mag_a_q : {WIDTH{1'b0}};
  assign sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign p_step = {sum, p_q[WIDTH-1:1]};
  assign last   = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    result_d = result_q;
    mag_a_d  = mag_a_q;
    neg_d    = neg_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mag_a_d = mag_a_in;
          neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          p_d     = {{WIDTH{1'b0}}, mag_b_in};
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        p_d   = p_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          result_d = neg_q ? ({(2*WIDTH){1'b0}} - p_step) : p_step;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      p_q      <= '0;
      result_q <= '0;
      mag_a_q  <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      result_q <= result_d;
      mag_a_q  <= mag_a_d;
      neg_q    <= neg_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StBusy);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult at WIDTH=8: corner products, latency, backpressure,
// mid-operation reset, back-to-back throughput, plus a random sweep against a product model.
module tb_seq_mult;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           signed_mode = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  seq_mult #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic sm);
    logic signed [15:0] sx, sy, sp;
    logic [15:0] ux, uy;
    sx = {{8{x[7]}}, x};
    sy = {{8{y[7]}}, y};
    ux = {8'h00, x};
    uy = {8'h00, y};
    sp = sx * sy;
    return sm ? sp : (ux * uy);
  endfunction

  task automatic ack(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ack_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ack_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Issue one operation, check fixed latency and result; optionally complete the handshake.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic sm, input logic [15:0] exp_res, input bit do_ack);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta;
    b = tb_v;
    signed_mode = sm;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~ta;
    b = ~tb_v;
    signed_mode = ~sm;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (lat == 1) begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    if (do_ack) ack(tag);
  endtask

  logic [7:0]  bb_a  [3];
  logic [7:0]  bb_b  [3];
  logic        bb_s  [3];
  logic [15:0] bb_e  [3];
  int          bb_cyc[3];

  initial begin
    logic [7:0] ra, rb;
    logic       rs;
    int idx, ridx, cyc;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    rst = 1'b0;

    // Corner products
    run_op("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
    run_op("s_fd_05", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b1);
    run_op("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
    run_op("s_80_7f", 8'h80, 8'h7F, 1'b1, 16'hC080, 1'b1);
    run_op("u_fd_05", 8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b1);
    run_op("s_ff_ff", 8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b1);
    run_op("u_00_c8", 8'h00, 8'hC8, 1'b0, 16'h0000, 1'b1);
    run_op("u_01_ab", 8'h01, 8'hAB, 1'b0, 16'h00AB, 1'b1);

    // Backpressure: result held, new operands ignored
    run_op("bp", 8'h0B, 8'h0D, 1'b0, 16'h008F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result", 32'(result), 32'h008F);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      a = 8'h77;
      b = 8'h33;
      in_valid = i[0];
    end
    ack("bp");
    @(negedge clk);
    check("bp_not_captured", 32'(busy), 32'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("mid_rst_no_ghost", 32'(out_valid), 32'd0);
    run_op("after_rst", 8'h12, 8'h34, 1'b0, 16'h03A8, 1'b1);

    // Back-to-back with in_valid held and out_ready tied high
    bb_a[0] = 8'h00; bb_b[0] = 8'hC8; bb_s[0] = 1'b0; bb_e[0] = 16'h0000;
    bb_a[1] = 8'h01; bb_b[1] = 8'hAB; bb_s[1] = 1'b0; bb_e[1] = 16'h00AB;
    bb_a[2] = 8'h7F; bb_b[2] = 8'h81; bb_s[2] = 1'b1; bb_e[2] = 16'hC0FF;
    idx = 0;
    ridx = 0;
    cyc = 0;
    out_ready = 1'b1;
    while (ridx < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        check("b2b_result", 32'(result), 32'(bb_e[ridx]));
        bb_cyc[ridx] = cyc;
        ridx++;
      end
      if (in_ready && idx < 3) begin
        a = bb_a[idx];
        b = bb_b[idx];
        signed_mode = bb_s[idx];
        in_valid = 1'b1;
        idx++;
      end
    end
    check("b2b_count", 32'(ridx), 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_period_1", 32'(bb_cyc[1] - bb_cyc[0]), 32'(W + 2));
    check("b2b_period_2", 32'(bb_cyc[2] - bb_cyc[1]), 32'(W + 2));

    // Random sweep against the product model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      run_op("rand", ra, rb, rs, model(ra, rb, rs), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
